// File: rtl/ad9957_cdds_seq.sv
// Command sequencer producing the registered 10-bit cdds control word for the
// AD9957 function module: timed pulses, profile selection, playback gating and Tx enable.
module ad9957_cdds_seq #(
  parameter int MRST_LEN = 16,
  parameter int IORS_LEN = 4,
  parameter int IOUP_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  output logic        busy,
  output logic [9:0]  cdds
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROF_SET,
    S_PULSE,
    S_PLAY_RST,
    S_PLAY,
    S_GAP
  } state_t;

  // Which cdds bit the shared pulse counter is currently timing.
  typedef enum logic [1:0] {
    SEL_MRST,
    SEL_IORS,
    SEL_IOUP,
    SEL_WRST
  } sel_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MRST = 3'd1;
  localparam logic [2:0] OP_IORS = 3'd2;
  localparam logic [2:0] OP_PROF = 3'd3;
  localparam logic [2:0] OP_IOUP = 3'd4;
  localparam logic [2:0] OP_PLAY = 3'd5;
  localparam logic [2:0] OP_TXEN = 3'd6;
  localparam logic [2:0] OP_WRST = 3'd7;

  localparam logic [7:0] MRST_L = 8'(MRST_LEN);
  localparam logic [7:0] IORS_L = 8'(IORS_LEN);
  localparam logic [7:0] IOUP_L = 8'(IOUP_LEN);

  state_t      state,     state_nxt;
  sel_t        pulse_sel, pulse_sel_nxt;
  logic [7:0]  pulse_cnt, pulse_cnt_nxt;
  logic [15:0] play_cnt,  play_cnt_nxt;
  logic [2:0]  prof,      prof_nxt;
  logic        txen_lvl,  txen_lvl_nxt;
  logic [9:0]  cdds_nxt;
  logic        accept;

  assign cmd_rdy = (state == S_IDLE);
  assign busy    = (state != S_IDLE);
  assign accept  = cmd_vld && cmd_rdy;

  // State and datapath registers; reset has priority over any accept.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and process ordering cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pulse_sel <= SEL_MRST;
      pulse_cnt <= '0;
      play_cnt  <= '0;
      prof      <= '0;
      txen_lvl  <= 1'b0;
      cdds      <= '0;
    end else begin
      state     <= state_nxt;
      pulse_sel <= pulse_sel_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      play_cnt  <= play_cnt_nxt;
      prof      <= prof_nxt;
      txen_lvl  <= txen_lvl_nxt;
      cdds      <= cdds_nxt;
    end
  end

  // Next-state and counter logic.
  // NOTE: every signal gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    pulse_sel_nxt = pulse_sel;
    pulse_cnt_nxt = pulse_cnt;
    play_cnt_nxt  = play_cnt;
    prof_nxt      = prof;
    txen_lvl_nxt  = txen_lvl;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_NOP: begin
            end
            OP_MRST: begin
              state_nxt     = S_PULSE;
              pulse_sel_nxt = SEL_MRST;
              pulse_cnt_nxt = MRST_L;
              prof_nxt      = '0;
              txen_lvl_nxt  = 1'b0;
            end
            OP_IORS: begin
              state_nxt     = S_PULSE;
              pulse_sel_nxt = SEL_IORS;
              pulse_cnt_nxt = IORS_L;
            end
            OP_PROF: begin
              state_nxt = S_PROF_SET;
              prof_nxt  = cmd_arg[2:0];
            end
            OP_IOUP: begin
              state_nxt     = S_PULSE;
              pulse_sel_nxt = SEL_IOUP;
              pulse_cnt_nxt = IOUP_L;
            end
            OP_PLAY: begin
              state_nxt    = S_PLAY_RST;
              play_cnt_nxt = cmd_arg;
            end
            OP_TXEN: begin
              txen_lvl_nxt = cmd_arg[0];
            end
            OP_WRST: begin
              state_nxt     = S_PULSE;
              pulse_sel_nxt = SEL_WRST;
              pulse_cnt_nxt = 8'd1;
            end
            default: begin
            end
          endcase
        end
      end

      S_PROF_SET: begin
        state_nxt     = S_PULSE;
        pulse_sel_nxt = SEL_IOUP;
        pulse_cnt_nxt = IOUP_L;
      end

      S_PULSE: begin
        if (pulse_cnt <= 8'd1) begin
          state_nxt     = S_GAP;
          pulse_cnt_nxt = '0;
        end else begin
          pulse_cnt_nxt = pulse_cnt - 8'd1;
        end
      end

      // A zero-length playback still issues the buffer reset, then skips gating.
      S_PLAY_RST: begin
        state_nxt = (play_cnt == 16'd0) ? S_GAP : S_PLAY;
      end

      S_PLAY: begin
        if (play_cnt <= 16'd1) begin
          state_nxt    = S_GAP;
          play_cnt_nxt = '0;
        end else begin
          play_cnt_nxt = play_cnt - 16'd1;
        end
      end

      S_GAP: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output word is derived from the upcoming state and registered into cdds,
  // so no cmd_* input reaches the pins without passing a flop.
  always_comb begin
    logic pulse_on;
    logic pben;
    pulse_on = (state_nxt == S_PULSE);
    pben     = (state_nxt == S_PLAY);
    cdds_nxt = '0;
    cdds_nxt[0]   = pulse_on && (pulse_sel_nxt == SEL_IOUP);
    cdds_nxt[3:1] = prof_nxt;
    cdds_nxt[4]   = pulse_on && (pulse_sel_nxt == SEL_MRST);
    cdds_nxt[5]   = pulse_on && (pulse_sel_nxt == SEL_IORS);
    cdds_nxt[6]   = pulse_on && (pulse_sel_nxt == SEL_WRST);
    cdds_nxt[7]   = (state_nxt == S_PLAY_RST);
    cdds_nxt[8]   = pben;
    cdds_nxt[9]   = txen_lvl_nxt | pben;
  end

  // At most one timed bit may be active in any cycle.
  a_pulse_exclusive : assert property (@(posedge clk) disable iff (rst)
    $onehot0({cdds[0], cdds[4], cdds[5], cdds[6], cdds[7], cdds[8]}));

  a_pben_forces_txen : assert property (@(posedge clk) disable iff (rst)
    cdds[8] |-> cdds[9]);

endmodule

// File: doc/ad9957_cdds_seq.md
# ad9957_cdds_seq

Command-driven sequencer that generates the 10-bit `cdds` control word consumed by the AD9957 function module. It turns single-cycle commands into correctly timed, fixed-width pulses and level changes: master reset, I/O reset, I/O update, profile switch, playback buffer resets, playback gating and Tx enable. It sits directly upstream of the DDS function module's `cdds` input. It is the only block allowed to drive that bus.

## Interface

Parameters:
- `MRST_LEN`, default 16: master-reset pulse width in clk cycles, 1..255.
- `IORS_LEN`, default 4: I/O-reset pulse width in cycles, 1..255.
- `IOUP_LEN`, default 4: I/O-update pulse width in cycles, 1..255.

Ports:
- `clk` in, 1: system clock; the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `cmd_vld` in, 1: command valid.
- `cmd_rdy` out, 1: sequencer can accept a command.
- `cmd_op` in, 3: opcode.
- `cmd_arg` in, 16: opcode argument.
- `busy` out, 1: high whenever the state is not IDLE.
- `cdds` out, 10: control word. Bit mapping:
  - [0] ioup
  - [3:1] prof
  - [4] mrst
  - [5] iors
  - [6] wrst
  - [7] rrst
  - [8] pben
  - [9] txen

## Operation

- All `cdds` bits are registered. `cdds` has no combinational path from the `cmd_*` inputs.
- Handshake:
  - `cmd_rdy = (state==IDLE)`.
  - A command is accepted on a cycle where `cmd_vld && cmd_rdy`.
  - When `cmd_rdy` is low, `cmd_*` is ignored and not latched.
- Opcodes:
  - 0 NOP: accepted; no effect; state stays IDLE.
  - 1 MRST: mrst high for `MRST_LEN` cycles. At the start of the pulse, prof, pben and the txen level clear to 0.
  - 2 IORS: iors high for `IORS_LEN` cycles.
  - 3 PROF: prof takes `cmd_arg[2:0]` on the first cycle. ioup then goes high for `IOUP_LEN` cycles, starting one cycle later.
  - 4 IOUP: ioup high for `IOUP_LEN` cycles.
  - 5 PLAY:
    - rrst high for 1 cycle.
    - Then pben high for `cmd_arg` cycles, with txen forced high during the same cycles.
    - If `cmd_arg==0`, the rrst pulse is issued and the pben phase is skipped.
  - 6 TXEN: the txen level register takes `cmd_arg[0]`. Single cycle; no pulse.
  - 7 WRST: wrst high for 1 cycle.
- Output composition: `cdds[9] = txen_lvl | play_active`. prof holds its value between commands.
- States: IDLE, PROF_SET, PULSE, PLAY_RST, PLAY, GAP.
  - IDLE:
    - op 1/2/4/7 go to PULSE.
    - op 3 goes to PROF_SET.
    - op 5 goes to PLAY_RST.
    - op 0/6 stay in IDLE.
  - PROF_SET (1 cycle) goes to PULSE, with the ioup pulse loaded.
  - PULSE: a down-counter is loaded with the pulse length. When it reaches its last count, go to GAP.
  - PLAY_RST (1 cycle) goes to PLAY, or to GAP if `cmd_arg==0`.
  - PLAY: a 16-bit down-counter is loaded with `cmd_arg`. On its last count, go to GAP.
  - GAP: 1 cycle with all pulse bits low, then IDLE. GAP guarantees at least 1 low cycle between consecutive pulses on any bit.
- `rst`:
  - Takes effect at the next edge, including mid-pulse or mid-playback.
  - State goes to IDLE and all counters and `cdds` go to 0. txen_lvl goes to 0 and prof to 0.
  - `cmd_rdy` is 1 on the first cycle after the reset edge when `rst` is low.
  - No command is accepted while `rst` is high.

## Timing

- Reset values: `cdds`=10'h000, `busy`=0, `cmd_rdy`=1 (after reset is released).
- Command accepted at edge n: the affected `cdds` bits change at edge n+1.
- Pulse of length L starting at n+1: the bit is high for edges n+1..n+L and low at n+L+1.
- Timeline after the pulse ends at n+L+1:
  - GAP occupies n+L+1.
  - `cmd_rdy` goes high at n+L+2.
  - The next pulse can start no earlier than n+L+3.
- PROF timeline:
  - prof changes at n+1.
  - ioup is high for edges n+2..n+1+`IOUP_LEN`.
  - `cmd_rdy` goes high at n+3+`IOUP_LEN`.
- PLAY with arg A>0:
  - rrst at n+1.
  - pben and txen high for edges n+2..n+1+A.
  - `cmd_rdy` goes high at n+3+A.
- PLAY with arg 0: rrst at n+1, GAP at n+2, `cmd_rdy` at n+3.
- TXEN: txen at n+1; `cmd_rdy` remains 1 (back-to-back accepts allowed).
- Counter widths:
  - The pulse counter is 8 bits.
  - The play counter is 16 bits; A=65535 is the maximum and must not wrap.

## Test plan

- Reset: assert `rst` for 3 cycles, then release. Required: `cdds`=0, `cmd_rdy`=1, `busy`=0; the first accept is honoured on the cycle after release.
- MRST with defaults: op1 at edge n. Required:
  - mrst is high for exactly 16 cycles (n+1..n+16).
  - prof, pben and txen read 0.
  - `cmd_rdy` reasserts at n+18.
- PROF:
  - op3 with arg=5. Required: prof=3'b101 at n+1; ioup high n+2..n+5; prof is still 5 after the command completes.
  - A second op3 presented while busy is not accepted until `cmd_rdy` is high.
- PLAY arg=3 after TXEN arg=0. Required:
  - rrst at n+1.
  - pben and txen high n+2..n+4, txen 0 again at n+5.
  - Repeat with arg=0: only the rrst pulse appears.
- Back-to-back:
  - TXEN 1, then IOUP, with `cmd_vld` held high. Required: txen=1 at n+1; ioup high for exactly 4 cycles starting the cycle after the IOUP accept; txen stays 1.
- Reset mid-PLAY: PLAY arg=100, with `rst` pulsed at cycle 40 of pben. Required: all `cdds` bits are 0 on the next edge and state returns to IDLE; the counter does not resume after reset.
